// File: rtl/com_bus_arbiter_rr_pkg.sv
// Shared types and helpers for the coherence-bus round-robin arbiter.
package arb_pkg;

  // Top-level bus ownership states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PROC_OWN = 2'd1,
    TURN     = 2'd2
  } arb_state_e;

  // Pointer width for an N-way arbiter; a 1-way arbiter still gets one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index one past the winner, wrapping from n-1 back to 0.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: grants the first requester at or
// after ptr, scanning upward and wrapping. Output is one-hot or zero.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;

  // Scan requesters starting at ptr; first hit wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (enable && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/com_bus_arbiter_rr.sv
// Coherence-bus arbiter: round-robin processor ownership with bounded tenure,
// and nested snoop-phase arbitration (caches round-robin, memory last) that
// only runs while a processor owns the bus. All outputs are registered.
module com_bus_arbiter_rr
  import arb_pkg::*;
#(
  parameter int NUM_PROC  = 8,
  parameter int NUM_SNOOP = 4,
  parameter int MAX_HOLD  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
  output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
  input  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop,
  output logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop,
  input  logic                 Mem_snoop_req,
  output logic                 Mem_snoop_gnt,
  output logic                 Bus_busy,
  output logic                 Gnt_timeout
);

  localparam int PPW      = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam int SPW      = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1;
  localparam int CW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_SAT = (MAX_HOLD > 0) ? MAX_HOLD : 1;

  arb_state_e           state;
  logic [PPW-1:0]       proc_ptr;
  logic [SPW-1:0]       snoop_ptr;
  logic [CW-1:0]        hold_cnt;

  logic [NUM_PROC-1:0]  proc_win;
  logic [NUM_SNOOP-1:0] snoop_win;
  logic [PPW-1:0]       proc_win_idx;
  logic [SPW-1:0]       snoop_win_idx;
  logic                 owner_req;
  logic                 snoop_owner_req;
  logic                 hold_expired;

  // Processor-level arbitration is only consulted in IDLE.
  rr_arbiter #(.N(NUM_PROC)) u_proc_arb (
    .req    (Com_Bus_Req_proc),
    .ptr    (proc_ptr),
    .enable (state == IDLE),
    .gnt    (proc_win)
  );

  // Cache-snoop arbitration is only meaningful while a processor owns the bus.
  rr_arbiter #(.N(NUM_SNOOP)) u_snoop_arb (
    .req    (Com_Bus_Req_snoop),
    .ptr    (snoop_ptr),
    .enable (state == PROC_OWN),
    .gnt    (snoop_win)
  );

  // Encode the one-hot winners into indices for pointer rotation.
  always_comb begin
    proc_win_idx  = '0;
    snoop_win_idx = '0;
    for (int i = 0; i < NUM_PROC; i++)
      if (proc_win[i]) proc_win_idx = PPW'(i);
    for (int j = 0; j < NUM_SNOOP; j++)
      if (snoop_win[j]) snoop_win_idx = SPW'(j);
  end

  // Ownership status of the current grants.
  always_comb begin
    owner_req       = |(Com_Bus_Req_proc & Com_Bus_Gnt_proc);
    snoop_owner_req = |(Com_Bus_Req_snoop & Com_Bus_Gnt_snoop);
    // The counter reads MAX_HOLD-1 during the last allowed cycle of tenure.
    hold_expired    = (MAX_HOLD != 0) && (hold_cnt == CW'(MAX_HOLD - 1));
  end

  // Ownership FSM with registered grants, pointers and hold counter.
  // NOTE: reset is asynchronous so every grant drops the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      proc_ptr          <= '0;
      snoop_ptr         <= '0;
      hold_cnt          <= '0;
      Com_Bus_Gnt_proc  <= '0;
      Com_Bus_Gnt_snoop <= '0;
      Mem_snoop_gnt     <= 1'b0;
      Bus_busy          <= 1'b0;
      Gnt_timeout       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      Gnt_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|Com_Bus_Req_proc) begin
            state            <= PROC_OWN;
            Com_Bus_Gnt_proc <= proc_win;
            Bus_busy         <= 1'b1;
            proc_ptr         <= PPW'(next_ptr(int'(proc_win_idx), NUM_PROC));
            hold_cnt         <= '0;
          end
        end

        PROC_OWN: begin
          if (!owner_req || hold_expired) begin
            // A voluntary release takes precedence over a coincident timeout.
            state             <= TURN;
            Com_Bus_Gnt_proc  <= '0;
            Com_Bus_Gnt_snoop <= '0;
            Mem_snoop_gnt     <= 1'b0;
            Bus_busy          <= 1'b0;
            Gnt_timeout       <= owner_req;
          end else begin
            if (hold_cnt != CW'(HOLD_SAT))
              hold_cnt <= hold_cnt + 1'b1;
            // Snoop phase: current owner keeps its grant while requesting;
            // otherwise caches are arbitrated before memory.
            if (snoop_owner_req) begin
              Com_Bus_Gnt_snoop <= Com_Bus_Gnt_snoop;
            end else if (Mem_snoop_gnt && Mem_snoop_req) begin
              Mem_snoop_gnt <= 1'b1;
            end else if (|Com_Bus_Req_snoop) begin
              Com_Bus_Gnt_snoop <= snoop_win;
              Mem_snoop_gnt     <= 1'b0;
              snoop_ptr         <= SPW'(next_ptr(int'(snoop_win_idx), NUM_SNOOP));
            end else begin
              Com_Bus_Gnt_snoop <= '0;
              Mem_snoop_gnt     <= Mem_snoop_req;
            end
          end
        end

        TURN: begin
          state <= IDLE;
        end

        default: begin
          state             <= IDLE;
          Com_Bus_Gnt_proc  <= '0;
          Com_Bus_Gnt_snoop <= '0;
          Mem_snoop_gnt     <= 1'b0;
          Bus_busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_com_bus_arbiter_rr.sv
// Directed bench for com_bus_arbiter_rr (NUM_PROC=8, NUM_SNOOP=4, MAX_HOLD=16).
module tb_com_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_proc;
  logic [7:0] gnt_proc;
  logic [3:0] req_snoop;
  logic [3:0] gnt_snoop;
  logic       mem_req;
  logic       mem_gnt;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  com_bus_arbiter_rr #(.NUM_PROC(8), .NUM_SNOOP(4), .MAX_HOLD(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Com_Bus_Req_proc  (req_proc),
    .Com_Bus_Gnt_proc  (gnt_proc),
    .Com_Bus_Req_snoop (req_snoop),
    .Com_Bus_Gnt_snoop (gnt_snoop),
    .Mem_snoop_req     (mem_req),
    .Mem_snoop_gnt     (mem_gnt),
    .Bus_busy          (busy),
    .Gnt_timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All bus outputs at once.
  task automatic check_all(input string tag, input logic [7:0] gp, input logic [3:0] gs,
                           input logic gm, input logic b, input logic t);
    check({tag, ".gnt_proc"},  32'(gnt_proc),  32'(gp));
    check({tag, ".gnt_snoop"}, 32'(gnt_snoop), 32'(gs));
    check({tag, ".mem_gnt"},   32'(mem_gnt),   32'(gm));
    check({tag, ".busy"},      32'(busy),      32'(b));
    check({tag, ".timeout"},   32'(timeout),   32'(t));
  endtask

  initial begin
    logic [7:0] exp_g;

    rst_n     = 1'b0;
    req_proc  = '0;
    req_snoop = '0;
    mem_req   = 1'b0;
    #12;
    check_all("reset", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    check_all("idle_after_reset", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);

    // Rotation: all request, each owner releases after three cycles.
    req_proc = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_g = 8'h01 << (k % 8);
      tick();
      check($sformatf("rot%0d.grant", k), 32'(gnt_proc), 32'(exp_g));
      check($sformatf("rot%0d.busy", k), 32'(busy), 32'h1);
      tick();
      tick();
      check($sformatf("rot%0d.held", k), 32'(gnt_proc), 32'(exp_g));
      req_proc = req_proc & ~exp_g;
      tick();
      check($sformatf("rot%0d.release", k), 32'(gnt_proc), 32'h0);
      check($sformatf("rot%0d.timeout", k), 32'(timeout), 32'h0);
      req_proc = 8'hFF;
      tick();
      check($sformatf("rot%0d.turn_gap", k), 32'(gnt_proc), 32'h0);
    end
    req_proc = 8'h00;
    tick();
    check_all("rot_end_idle", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);

    // Single request, proc 2 (pointer now 1).
    req_proc = 8'h04;
    tick();
    check_all("single_grant", 8'h04, 4'h0, 1'b0, 1'b1, 1'b0);
    req_proc = 8'h00;
    tick();
    check_all("single_release", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check("single_idle", 32'(gnt_proc), 32'h0);

    // Timeout: proc 3 and proc 5 request; pointer is 3 so proc 3 wins first.
    req_proc = 8'h28;
    for (int c = 1; c <= 16; c++) begin
      tick();
      check($sformatf("hold_c%0d.grant", c), 32'(gnt_proc), 32'h08);
      check($sformatf("hold_c%0d.timeout", c), 32'(timeout), 32'h0);
    end
    tick();
    check_all("timeout_release", 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
    tick();
    check_all("timeout_pulse_end", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("after_timeout_proc5", 8'h20, 4'h0, 1'b0, 1'b1, 1'b0);
    req_proc = 8'h00;
    tick();
    tick();

    // Snoop nesting: proc 2 owns, caches 1 and 3 plus memory request at once.
    req_proc = 8'h04;
    tick();
    check_all("snoop_owner", 8'h04, 4'h0, 1'b0, 1'b1, 1'b0);
    req_snoop = 4'b1010;
    mem_req   = 1'b1;
    tick();
    check_all("snoop_first", 8'h04, 4'b0010, 1'b0, 1'b1, 1'b0);
    tick();
    check_all("snoop_hold", 8'h04, 4'b0010, 1'b0, 1'b1, 1'b0);
    req_snoop = 4'b1000;
    tick();
    check_all("snoop_second", 8'h04, 4'b1000, 1'b0, 1'b1, 1'b0);
    req_snoop = 4'b0000;
    tick();
    check_all("snoop_mem", 8'h04, 4'b0000, 1'b1, 1'b1, 1'b0);
    mem_req = 1'b0;
    tick();
    check_all("snoop_mem_drop", 8'h04, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Owner release while a cache holds the snoop grant.
    req_snoop = 4'b0001;
    tick();
    check("rel_snoop_grant", 32'(gnt_snoop), 32'h1);
    req_proc = 8'h00;
    tick();
    check_all("rel_all_clear", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    req_snoop = 4'b0000;
    tick();
    tick();

    // Asynchronous reset between edges while proc 4 owns the bus.
    req_proc = 8'h10;
    tick();
    check("areset_pre_grant", 32'(gnt_proc), 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("areset_immediate", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    req_proc = 8'h81;
    tick();
    #1;
    rst_n = 1'b1;
    tick();
    check_all("areset_ptr_zero", 8'h01, 4'h0, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
